// File: rtl/axis_rr_arb.sv
// axis_rr_arb: round-robin AXI-Stream arbiter; define AXIS_RR_ARB_PACKET_LOCK_EN to hold grant until tlast.
module axis_rr_arb #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_NUM_SRC    = 4,
  parameter int P_ID_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [P_NUM_SRC-1:0]              s_axis_tvalid,
  output logic [P_NUM_SRC-1:0]              s_axis_tready,
  input  logic [P_NUM_SRC*P_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [P_NUM_SRC-1:0]              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [P_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic [P_ID_WIDTH-1:0]             m_axis_tid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [P_ID_WIDTH-1:0] grant_idx, last_idx, grant_nxt, last_nxt, pick, idx;
  logic gnt, xfer, rel;
  // Walk downwards so the nearest valid source after last_idx wins.
  always_comb begin
    pick = last_idx;
    idx = '0;
    for (int k = P_NUM_SRC; k >= 1; k--) begin
      idx = P_ID_WIDTH'((int'(last_idx) + k) % P_NUM_SRC);
      if (s_axis_tvalid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    last_nxt = last_idx;
    gnt = state == GRANT && !rst;
    m_axis_tvalid = gnt && s_axis_tvalid[grant_idx];
    m_axis_tdata = s_axis_tdata[grant_idx*P_DATA_WIDTH +: P_DATA_WIDTH];
    m_axis_tlast = s_axis_tlast[grant_idx];
    m_axis_tid = gnt ? grant_idx : '0;
    s_axis_tready = gnt && m_axis_tready ? P_NUM_SRC'(1) << grant_idx : '0;
    xfer = m_axis_tvalid && m_axis_tready;
`ifdef AXIS_RR_ARB_PACKET_LOCK_EN
    rel = xfer && m_axis_tlast;
`else
    rel = xfer;
`endif
    if (state == IDLE && |s_axis_tvalid) begin
      state_nxt = GRANT;
      grant_nxt = pick;
    end
    if (state == GRANT && rel) begin
      state_nxt = IDLE;
      last_nxt = grant_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_idx <= '0;
      last_idx <= P_ID_WIDTH'(P_NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      grant_idx <= grant_nxt;
      last_idx <= last_nxt;
    end
  end
endmodule

// File: tb/tb_axis_rr_arb.sv
// tb_axis_rr_arb: directed bench with a per-cycle arbitration model and hand-computed anchors.
module tb_axis_rr_arb;
  localparam int N = 4;
  localparam int W = 8;
`ifdef AXIS_RR_ARB_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
  localparam int E3[5] = '{1, 1, 1, 3, 3};
`else
  localparam bit LOCK = 1'b0;
  localparam int E3[5] = '{1, 3, 1, 3, 1};
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] s_tv, s_tr, s_tl;
  logic [N*W-1:0] s_td;
  logic m_tv, m_tr, m_tl;
  logic [W-1:0] m_td;
  logic [1:0] m_tid;
  logic [8:0] q[N][$];
  bit en[N];
  bit busy;
  int src, lst, cyc_n, tests, fails;
  int lg_cyc[$], lg_tid[$], lg_dat[$], lg_rdy[$];

  axis_rr_arb #(.P_DATA_WIDTH(W), .P_NUM_SRC(N), .P_ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tv), .s_axis_tready(s_tr), .s_axis_tdata(s_td), .s_axis_tlast(s_tl),
    .m_axis_tvalid(m_tv), .m_axis_tready(m_tr), .m_axis_tdata(m_td), .m_axis_tlast(m_tl),
    .m_axis_tid(m_tid)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic int at(int qq[$], int k);
    return k < qq.size() ? qq[k] : -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [8:0] b;
      b = q[i].size() > 0 ? q[i][0] : 9'h0;
      s_tv[i] = en[i] && q[i].size() > 0;
      s_td[i*W +: W] = b[7:0];
      s_tl[i] = b[8];
    end
  endtask

  // Model: a grant is either pending arbitration or owned by src; sources are queues.
  task automatic cyc();
    logic [8:0] b;
    bit on, mv, xfer;
    int ps;
    b = 9'h0;
    @(negedge clk);
    cyc_n++;
    on = !rst && busy;
    mv = on && s_tv[src[1:0]];
    chk("m_tvalid", 32'(m_tv), 32'(mv));
    chk("m_tid", 32'(m_tid), on ? src : 0);
    chk("s_tready", 32'(s_tr), on && m_tr ? 32'd1 << src : 32'd0);
    if (mv) begin
      b = q[src][0];
      chk("m_tdata", 32'(m_td), 32'(b[7:0]));
      chk("m_tlast", 32'(m_tl), 32'(b[8]));
    end
    if (m_tv && m_tr) begin
      lg_cyc.push_back(cyc_n);
      lg_tid.push_back(int'(m_tid));
      lg_dat.push_back(int'(m_td));
      lg_rdy.push_back(int'(s_tr));
    end
    xfer = mv && m_tr;
    ps = src;
    if (rst) begin
      busy = 0;
      src = 0;
      lst = N - 1;
    end else if (!busy) begin
      if (|s_tv) begin
        for (int k = 1; k <= N; k++)
          if (s_tv[(lst + k) % N]) begin
            src = (lst + k) % N;
            break;
          end
        busy = 1;
      end
    end else if (xfer && (!LOCK || b[8])) begin
      busy = 0;
      lst = src;
    end
    @(posedge clk);
    #1;
    if (xfer) void'(q[ps].pop_front());
    drive();
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (pending() > 0 && n < 200) begin
      cyc();
      n++;
    end
    cyc();
    cyc();
    chk(nm, pending(), 0);
  endtask

  task automatic clear_log();
    lg_cyc.delete();
    lg_tid.delete();
    lg_dat.delete();
    lg_rdy.delete();
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    m_tr = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1;
      q[i].push_back(9'h100 | 9'(8'h10 + i));
      q[i].push_back(9'h100 | 9'(8'h20 + i));
    end
    drive();
    repeat (2) cyc();
    rst = 1'b0;
    drive();
    drain("t1 drain");
    for (int k = 0; k < 5; k++) chk("t1 tid order", at(lg_tid, k), k % 4);
    for (int k = 0; k < 4; k++) chk("t1 beat spacing", at(lg_cyc, k + 1) - at(lg_cyc, k), 2);
    chk("t1 first data", at(lg_dat, 0), 32'h10);
    chk("t1 fifth data", at(lg_dat, 4), 32'h20);

    clear_log();
    q[2].push_back(9'h1A5);
    drive();
    c0 = cyc_n + 1;
    drain("t2 drain");
    chk("t2 xfer cycle", at(lg_cyc, 0), c0 + 1);
    chk("t2 tid", at(lg_tid, 0), 2);
    chk("t2 data", at(lg_dat, 0), 32'hA5);
    chk("t2 s_tready", at(lg_rdy, 0), 32'b0100);
    chk("t2 beat count", lg_tid.size(), 1);

    clear_log();
    rst = 1'b1;
    q[1].push_back(9'h011);
    q[1].push_back(9'h012);
    q[1].push_back(9'h113);
    for (int i = 1; i <= 3; i++) q[3].push_back(9'h100 | 9'(8'h30 + i));
    drive();
    cyc();
    rst = 1'b0;
    drive();
    drain("t3 drain");
    for (int k = 0; k < 5; k++) chk("t3 tid order", at(lg_tid, k), E3[k]);
    chk("t3 first data", at(lg_dat, 0), 32'h11);

    clear_log();
    q[0].push_back(9'h177);
    m_tr = 1'b0;
    drive();
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t4 stall tvalid", 32'(m_tv), 1);
      chk("t4 stall tdata", 32'(m_td), 32'h77);
      chk("t4 stall s_tready", 32'(s_tr), 0);
      chk("t4 stall tid", 32'(m_tid), 0);
      cyc();
    end
    m_tr = 1'b1;
    drain("t4 drain");
    chk("t4 beat count", lg_tid.size(), 1);
    chk("t4 data", at(lg_dat, 0), 32'h77);

    clear_log();
    q[0].push_back(9'h101);
    q[2].push_back(9'h051);
    q[2].push_back(9'h052);
    q[2].push_back(9'h153);
    q[3].push_back(9'h161);
    drive();
    for (int n = 0; n < 10 && lg_tid.size() == 0; n++) cyc();
    chk("t5 first grant", at(lg_tid, 0), 2);
    rst = 1'b1;
    chk("t5 rst tvalid", 32'(m_tv), 0);
    chk("t5 rst tid", 32'(m_tid), 0);
    chk("t5 rst s_tready", 32'(s_tr), 0);
    cyc();
    rst = 1'b0;
    clear_log();
    drain("t5 drain");
    chk("t5 grant after rst", at(lg_tid, 0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
